// File: rtl/io_pkg.sv
// Shared definitions for the I/O port responder: default widths and FSM state encoding.
package io_pkg;

   localparam int DATA_W_DEF   = 16;
   localparam int IN_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_IN,
      WAIT_OUT
   } state_t;

endpackage

// File: rtl/io_fifo.sv
// Input buffer for the responder: power-of-two circular FIFO with occupancy counter.
module io_fifo
   import io_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = IN_DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [DATA_W-1:0]          din,
   output logic [DATA_W-1:0]          dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;

   // Storage carries no reset; only pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/io_port_responder.sv
// Processor I/O port responder: stalls IN/OUT requests until the external channels can service them.
module io_port_responder
   import io_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int IN_DEPTH = IN_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_en,
   input  logic              io_rd,
   input  logic              io_wr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              rd_valid,
   output logic              io_stall,
   input  logic              ext_in_valid,
   input  logic [DATA_W-1:0] ext_in_data,
   output logic              ext_in_ready,
   output logic              ext_out_valid,
   output logic [DATA_W-1:0] ext_out_data,
   input  logic              ext_out_ready
);

   localparam int CW = $clog2(IN_DEPTH) + 1;

   state_t            state;
   state_t            state_next;
   logic              pop;
   logic              push;
   logic              load_out;
   logic              stall_c;
   logic              in_full;
   logic              in_empty;
   logic              has_data;
   logic [CW-1:0]     in_count;
   logic [DATA_W-1:0] in_head;

   io_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (IN_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (ext_in_data),
      .dout  (in_head),
      .full  (in_full),
      .empty (in_empty),
      .count (in_count)
   );

   assign has_data     = !in_empty && (in_count != '0);
   assign ext_in_ready = reset && (!in_full || pop);
   assign push         = ext_in_valid && ext_in_ready;
   assign io_stall     = reset && stall_c;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // IN takes priority over OUT; dropping io_en abandons any pending wait.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      load_out   = 1'b0;
      stall_c    = 1'b0;
      unique case (state)
         IDLE: begin
            if (io_en && io_rd) begin
               if (has_data) begin
                  pop = 1'b1;
               end else begin
                  stall_c    = 1'b1;
                  state_next = WAIT_IN;
               end
            end else if (io_en && io_wr) begin
               if (!ext_out_valid || ext_out_ready) begin
                  load_out = 1'b1;
               end else begin
                  stall_c    = 1'b1;
                  state_next = WAIT_OUT;
               end
            end
         end
         WAIT_IN: begin
            if (!io_en) begin
               state_next = IDLE;
            end else if (has_data) begin
               pop        = 1'b1;
               state_next = IDLE;
            end else begin
               stall_c = 1'b1;
            end
         end
         WAIT_OUT: begin
            if (!io_en) begin
               state_next = IDLE;
            end else if (ext_out_ready) begin
               load_out   = 1'b1;
               state_next = IDLE;
            end else begin
               stall_c = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rdata    <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= pop;
         if (pop) begin
            rdata <= in_head;
         end
      end
   end

   // A new OUT load wins over the handshake clearing valid in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ext_out_valid <= 1'b0;
         ext_out_data  <= '0;
      end else if (load_out) begin
         ext_out_valid <= 1'b1;
         ext_out_data  <= wdata;
      end else if (ext_out_valid && ext_out_ready) begin
         ext_out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_io_port_responder.sv
// Scoreboard bench for io_port_responder: queued IN/OUT data checked as the DUT delivers it.
module tb_io_port_responder;

   localparam int DATA_W   = 16;
   localparam int IN_DEPTH = 4;

   logic              clk;
   logic              reset;
   logic              io_en;
   logic              io_rd;
   logic              io_wr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              rd_valid;
   logic              io_stall;
   logic              ext_in_valid;
   logic [DATA_W-1:0] ext_in_data;
   logic              ext_in_ready;
   logic              ext_out_valid;
   logic [DATA_W-1:0] ext_out_data;
   logic              ext_out_ready;

   int checks   = 0;
   int failures = 0;

   logic [DATA_W-1:0] in_q  [$];
   logic [DATA_W-1:0] out_q [$];
   logic [DATA_W-1:0] rd_exp;
   logic [DATA_W-1:0] out_exp;

   io_port_responder #(
      .DATA_W   (DATA_W),
      .IN_DEPTH (IN_DEPTH)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .io_en         (io_en),
      .io_rd         (io_rd),
      .io_wr         (io_wr),
      .wdata         (wdata),
      .rdata         (rdata),
      .rd_valid      (rd_valid),
      .io_stall      (io_stall),
      .ext_in_valid  (ext_in_valid),
      .ext_in_data   (ext_in_data),
      .ext_in_ready  (ext_in_ready),
      .ext_out_valid (ext_out_valid),
      .ext_out_data  (ext_out_data),
      .ext_out_ready (ext_out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard side: every rd_valid pulse and every output handshake must match the queue head.
   always @(negedge clk) begin
      if (rd_valid) begin
         checks++;
         if (in_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL rd_scoreboard: unexpected rd_valid with rdata=%h, required no pulse", rdata);
         end else begin
            rd_exp = in_q.pop_front();
            if (rdata !== rd_exp) begin
               failures++;
               $display("[TB] FAIL rd_scoreboard: rdata=%h, required %h", rdata, rd_exp);
            end
         end
      end
      if (ext_out_valid && ext_out_ready) begin
         checks++;
         if (out_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL out_scoreboard: unexpected transfer of %h, required none", ext_out_data);
         end else begin
            out_exp = out_q.pop_front();
            if (ext_out_data !== out_exp) begin
               failures++;
               $display("[TB] FAIL out_scoreboard: ext_out_data=%h, required %h", ext_out_data, out_exp);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0; io_en = 1'b1; io_rd = 1'b1; io_wr = 1'b1; wdata = 16'hFFFF;
      ext_in_valid = 1'b1; ext_in_data = 16'hFFFF; ext_out_ready = 1'b1;
      cyc(); cyc(); settle();
      checks++; if (rdata !== 16'h0) begin failures++; $display("[TB] FAIL reset_rdata: got %h, required 0000", rdata); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid: got %b, required 0", rd_valid); end
      checks++; if (ext_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b, required 0", ext_out_valid); end
      checks++; if (ext_out_data !== 16'h0) begin failures++; $display("[TB] FAIL reset_out_data: got %h, required 0000", ext_out_data); end
      checks++; if (io_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b, required 0", io_stall); end
      checks++; if (ext_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %b, required 0", ext_in_ready); end
      io_en = 1'b0; io_rd = 1'b0; io_wr = 1'b0; ext_in_valid = 1'b0; ext_out_ready = 1'b0;
      reset = 1'b1;
      settle();
      checks++; if (ext_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL release_in_ready: got %b, required 1", ext_in_ready); end
   endtask

   task automatic test_in_basic();
      cyc(); ext_in_valid = 1'b1; ext_in_data = 16'h1111; in_q.push_back(16'h1111);
      cyc(); ext_in_data = 16'h2222; in_q.push_back(16'h2222);
      cyc(); ext_in_valid = 1'b0; io_en = 1'b1; io_rd = 1'b1;
      settle();
      checks++; if (io_stall !== 1'b0) begin failures++; $display("[TB] FAIL in_basic_stall1: got %b, required 0", io_stall); end
      cyc(); settle();
      checks++; if (io_stall !== 1'b0) begin failures++; $display("[TB] FAIL in_basic_stall2: got %b, required 0", io_stall); end
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL in_basic_pulse1: got %b, required 1", rd_valid); end
      cyc(); io_en = 1'b0; io_rd = 1'b0; settle();
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL in_basic_pulse2: got %b, required 1", rd_valid); end
      cyc(); settle();
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL in_basic_pulse_end: got %b, required 0", rd_valid); end
      checks++; if (rdata !== 16'h2222) begin failures++; $display("[TB] FAIL in_basic_hold: got %h, required 2222", rdata); end
   endtask

   task automatic test_in_wait();
      io_en = 1'b1; io_rd = 1'b1; settle();
      checks++; if (io_stall !== 1'b1) begin failures++; $display("[TB] FAIL in_wait_stall_idle: got %b, required 1", io_stall); end
      cyc(); settle();
      checks++; if (io_stall !== 1'b1) begin failures++; $display("[TB] FAIL in_wait_stall_wait: got %b, required 1", io_stall); end
      cyc(); cyc();
      ext_in_valid = 1'b1; ext_in_data = 16'hBEEF; in_q.push_back(16'hBEEF);
      settle();
      checks++; if (io_stall !== 1'b1) begin failures++; $display("[TB] FAIL in_wait_no_bypass: got %b, required 1", io_stall); end
      cyc(); ext_in_valid = 1'b0; settle();
      checks++; if (io_stall !== 1'b0) begin failures++; $display("[TB] FAIL in_wait_release: got %b, required 0", io_stall); end
      cyc(); io_en = 1'b0; io_rd = 1'b0; settle();
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL in_wait_pulse: got %b, required 1", rd_valid); end
   endtask

   task automatic test_full();
      for (int i = 0; i < IN_DEPTH; i++) begin
         cyc(); ext_in_valid = 1'b1; ext_in_data = 16'h00A1 + 16'(i); in_q.push_back(16'h00A1 + 16'(i));
      end
      cyc(); ext_in_data = 16'h00C5; settle();
      checks++; if (ext_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready1: got %b, required 0", ext_in_ready); end
      cyc(); settle();
      checks++; if (ext_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready2: got %b, required 0", ext_in_ready); end
      io_en = 1'b1; io_rd = 1'b1; settle();
      checks++; if (ext_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_pop: got %b, required 1", ext_in_ready); end
      checks++; if (io_stall !== 1'b0) begin failures++; $display("[TB] FAIL full_stall: got %b, required 0", io_stall); end
      in_q.push_back(16'h00C5);
      cyc(); io_en = 1'b0; io_rd = 1'b0; ext_in_valid = 1'b0; settle();
      checks++; if (ext_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_still_full: got %b, required 0", ext_in_ready); end
      io_en = 1'b1; io_rd = 1'b1;
      repeat (IN_DEPTH) cyc();
      io_en = 1'b0; io_rd = 1'b0;
      cyc();
   endtask

   task automatic test_out();
      io_en = 1'b1; io_wr = 1'b1; wdata = 16'h00A5; settle();
      checks++; if (io_stall !== 1'b0) begin failures++; $display("[TB] FAIL out_first_stall: got %b, required 0", io_stall); end
      out_q.push_back(16'h00A5);
      cyc(); wdata = 16'h005A; settle();
      checks++; if (ext_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL out_valid: got %b, required 1", ext_out_valid); end
      checks++; if (io_stall !== 1'b1) begin failures++; $display("[TB] FAIL out_second_stall: got %b, required 1", io_stall); end
      cyc(); settle();
      checks++; if (io_stall !== 1'b1) begin failures++; $display("[TB] FAIL out_wait_stall: got %b, required 1", io_stall); end
      checks++; if (ext_out_data !== 16'h00A5) begin failures++; $display("[TB] FAIL out_data_stable: got %h, required 00a5", ext_out_data); end
      cyc(); ext_out_ready = 1'b1; settle();
      checks++; if (io_stall !== 1'b0) begin failures++; $display("[TB] FAIL out_stall_clear: got %b, required 0", io_stall); end
      out_q.push_back(16'h005A);
      cyc(); io_en = 1'b0; io_wr = 1'b0; settle();
      checks++; if (ext_out_valid !== 1'b1) begin failures++; $display("[TB] FAIL out_valid_kept: got %b, required 1", ext_out_valid); end
      checks++; if (ext_out_data !== 16'h005A) begin failures++; $display("[TB] FAIL out_second_data: got %h, required 005a", ext_out_data); end
      cyc(); ext_out_ready = 1'b0; settle();
      checks++; if (ext_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL out_valid_clear: got %b, required 0", ext_out_valid); end
   endtask

   task automatic test_both();
      cyc(); ext_in_valid = 1'b1; ext_in_data = 16'h7777; in_q.push_back(16'h7777);
      cyc(); ext_in_valid = 1'b0; io_en = 1'b1; io_rd = 1'b1; io_wr = 1'b1; wdata = 16'h1234; settle();
      checks++; if (io_stall !== 1'b0) begin failures++; $display("[TB] FAIL both_stall: got %b, required 0", io_stall); end
      cyc(); io_en = 1'b0; io_rd = 1'b0; io_wr = 1'b0; settle();
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL both_rd_valid: got %b, required 1", rd_valid); end
      checks++; if (ext_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL both_out_valid: got %b, required 0", ext_out_valid); end
      checks++; if (ext_out_data !== 16'h005A) begin failures++; $display("[TB] FAIL both_out_data: got %h, required 005a", ext_out_data); end
   endtask

   task automatic test_abort();
      cyc(); io_en = 1'b1; io_rd = 1'b1; settle();
      checks++; if (io_stall !== 1'b1) begin failures++; $display("[TB] FAIL abort_in_stall: got %b, required 1", io_stall); end
      cyc(); io_en = 1'b0; io_rd = 1'b0; settle();
      checks++; if (io_stall !== 1'b0) begin failures++; $display("[TB] FAIL abort_in_drop: got %b, required 0", io_stall); end
      cyc(); ext_in_valid = 1'b1; ext_in_data = 16'hC3C3;
      cyc(); ext_in_valid = 1'b0;
      cyc(); cyc(); settle();
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_in_no_pop: got %b, required 0", rd_valid); end
      io_en = 1'b1; io_rd = 1'b1; in_q.push_back(16'hC3C3); settle();
      checks++; if (io_stall !== 1'b0) begin failures++; $display("[TB] FAIL abort_in_kept: got %b, required 0", io_stall); end
      cyc(); io_en = 1'b0; io_rd = 1'b0; settle();
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL abort_in_read: got %b, required 1", rd_valid); end
      ext_out_ready = 1'b0; io_en = 1'b1; io_wr = 1'b1; wdata = 16'hB1B1; out_q.push_back(16'hB1B1);
      cyc(); wdata = 16'hB2B2; settle();
      checks++; if (io_stall !== 1'b1) begin failures++; $display("[TB] FAIL abort_out_stall: got %b, required 1", io_stall); end
      cyc(); io_en = 1'b0; io_wr = 1'b0; settle();
      checks++; if (io_stall !== 1'b0) begin failures++; $display("[TB] FAIL abort_out_drop: got %b, required 0", io_stall); end
      cyc(); ext_out_ready = 1'b1; settle();
      checks++; if (ext_out_data !== 16'hB1B1) begin failures++; $display("[TB] FAIL abort_out_data: got %h, required b1b1", ext_out_data); end
      cyc(); ext_out_ready = 1'b0; settle();
      checks++; if (ext_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_out_no_load: got %b, required 0", ext_out_valid); end
   endtask

   task automatic test_reset_mid_wait();
      for (int i = 0; i < 2; i++) begin
         cyc(); ext_in_valid = 1'b1; ext_in_data = 16'h00D1 + 16'(i);
      end
      cyc(); ext_in_valid = 1'b0; reset = 1'b0;
      cyc(); reset = 1'b1; io_en = 1'b1; io_rd = 1'b1; settle();
      checks++; if (io_stall !== 1'b1) begin failures++; $display("[TB] FAIL rst_discard_stall: got %b, required 1", io_stall); end
      cyc(); cyc();
      ext_in_valid = 1'b1; ext_in_data = 16'hEEEE; reset = 1'b0; settle();
      checks++; if (io_stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_wait_stall: got %b, required 0", io_stall); end
      checks++; if (ext_in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_wait_ready: got %b, required 0", ext_in_ready); end
      cyc(); settle();
      checks++; if (rdata !== 16'h0) begin failures++; $display("[TB] FAIL rst_wait_rdata: got %h, required 0000", rdata); end
      checks++; if (ext_out_data !== 16'h0) begin failures++; $display("[TB] FAIL rst_wait_out_data: got %h, required 0000", ext_out_data); end
      checks++; if (ext_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_wait_out_valid: got %b, required 0", ext_out_valid); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_wait_rd_valid: got %b, required 0", rd_valid); end
      ext_in_valid = 1'b0; io_en = 1'b0; io_rd = 1'b0; reset = 1'b1; settle();
      checks++; if (ext_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_wait_release_ready: got %b, required 1", ext_in_ready); end
      checks++; if (io_stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_wait_release_stall: got %b, required 0", io_stall); end
      cyc(); io_en = 1'b1; io_rd = 1'b1; settle();
      checks++; if (io_stall !== 1'b1) begin failures++; $display("[TB] FAIL rst_wait_empty_after: got %b, required 1", io_stall); end
      cyc(); io_en = 1'b0; io_rd = 1'b0;
      cyc();
   endtask

   initial begin
      $display("[TB] starting io_port_responder bench");
      test_reset();
      test_in_basic();
      test_in_wait();
      test_full();
      test_out();
      test_both();
      test_abort();
      test_reset_mid_wait();
      cyc(); cyc();
      checks++; if (in_q.size() != 0) begin failures++; $display("[TB] FAIL in_queue_drained: %0d left, required 0", in_q.size()); end
      checks++; if (out_q.size() != 0) begin failures++; $display("[TB] FAIL out_queue_drained: %0d left, required 0", out_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
